clock_set_ctrl: RTL



---
 rtl/clock_pkg.sv | 19 +
 rtl/mod_counter.sv | 34 +++
 rtl/clock_set_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and limits for the digital clock controller and its counters.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SET_TIME  = 2'd1,
        ST_SET_ALARM = 2'd2
    } state_t;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_HOUR = 3'b001;
    localparam logic [2:0] F_MIN  = 3'b010;
    localparam logic [2:0] F_SEC  = 3'b100;

    localparam int HOURS = 24;
    localparam int MINS  = 60;
    localparam int SECS  = 60;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with load and a combinational carry that flags the wrap.
module mod_counter #(
    parameter int MOD     = 60,
    parameter int W       = $clog2(MOD),
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_cnt,
    output logic         o_carry
);

    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

    logic [W-1:0] r_cnt;

    // Carry is combinational so cascaded counters advance in the same cycle.
    assign o_carry = i_inc & (r_cnt == MAX_VAL);
    assign o_cnt   = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= W'(RST_VAL);
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= (r_cnt == MAX_VAL) ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Digital clock controller: key-driven mode FSM, timekeeping, alarm setting and alarm ring.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int RING_SECS    = 30,
    parameter int ALM_RST_HOUR = 7,
    parameter int ALM_RST_MIN  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key_pulse,
    input  logic       tick_1hz,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [4:0] alm_hour,
    output logic [5:0] alm_min,
    output logic       alarm_en,
    output logic [1:0] state,
    output logic [2:0] field_sel,
    output logic       blink,
    output logic       alarm_ring
);

    localparam int RW = $clog2(RING_SECS + 1);

    state_t        r_state;
    logic [2:0]    r_field_sel;
    logic          r_alarm_en;
    logic          r_blink;
    logic          r_alarm_ring;
    logic [RW-1:0] r_ring_cnt;

    logic [4:0] w_hour, w_alm_hour;
    logic [5:0] w_min, w_sec, w_alm_min;
    logic       w_sec_carry, w_min_carry, w_hour_carry, w_amin_carry, w_ahour_carry;
    logic       w_unused_carry;

    // A key pressed while ringing only silences the alarm.
    logic w_cancel, w_mode, w_turn, w_change;
    assign w_cancel = r_alarm_ring & (|key_pulse);
    assign w_mode   = ~r_alarm_ring & key_pulse[0];
    assign w_turn   = ~r_alarm_ring & key_pulse[1] & ~key_pulse[0];
    assign w_change = ~r_alarm_ring & key_pulse[2] & ~key_pulse[1] & ~key_pulse[0];

    logic w_in_run, w_in_set_time, w_in_set_alarm, w_tick_time;
    assign w_in_run       = (r_state == ST_RUN);
    assign w_in_set_time  = (r_state == ST_SET_TIME);
    assign w_in_set_alarm = (r_state == ST_SET_ALARM);
    assign w_tick_time    = tick_1hz & ~w_in_set_time;

    // Edits in SET_TIME never carry; only tick-driven wraps ripple upward.
    logic w_sec_inc, w_min_inc, w_hour_inc, w_amin_inc, w_ahour_inc;
    assign w_sec_inc   = w_tick_time
                       | (w_change & w_in_set_time & (r_field_sel == F_SEC));
    assign w_min_inc   = (w_sec_carry & w_tick_time)
                       | (w_change & w_in_set_time & (r_field_sel == F_MIN));
    assign w_hour_inc  = (w_min_carry & w_tick_time)
                       | (w_change & w_in_set_time & (r_field_sel == F_HOUR));
    assign w_amin_inc  = w_change & w_in_set_alarm & (r_field_sel == F_MIN);
    assign w_ahour_inc = w_change & w_in_set_alarm & (r_field_sel == F_HOUR);

    assign w_unused_carry = w_hour_carry ^ w_amin_carry ^ w_ahour_carry;

    mod_counter #(.MOD(SECS), .W(6), .RST_VAL(0)) u_sec (
        .clk(clk), .rst_n(rst_n), .i_inc(w_sec_inc), .i_load(1'b0), .i_load_val(6'd0),
        .o_cnt(w_sec), .o_carry(w_sec_carry)
    );
    mod_counter #(.MOD(MINS), .W(6), .RST_VAL(0)) u_min (
        .clk(clk), .rst_n(rst_n), .i_inc(w_min_inc), .i_load(1'b0), .i_load_val(6'd0),
        .o_cnt(w_min), .o_carry(w_min_carry)
    );
    mod_counter #(.MOD(HOURS), .W(5), .RST_VAL(0)) u_hour (
        .clk(clk), .rst_n(rst_n), .i_inc(w_hour_inc), .i_load(1'b0), .i_load_val(5'd0),
        .o_cnt(w_hour), .o_carry(w_hour_carry)
    );
    mod_counter #(.MOD(MINS), .W(6), .RST_VAL(ALM_RST_MIN)) u_alm_min (
        .clk(clk), .rst_n(rst_n), .i_inc(w_amin_inc), .i_load(1'b0), .i_load_val(6'd0),
        .o_cnt(w_alm_min), .o_carry(w_amin_carry)
    );
    mod_counter #(.MOD(HOURS), .W(5), .RST_VAL(ALM_RST_HOUR)) u_alm_hour (
        .clk(clk), .rst_n(rst_n), .i_inc(w_ahour_inc), .i_load(1'b0), .i_load_val(5'd0),
        .o_cnt(w_alm_hour), .o_carry(w_ahour_carry)
    );

    // The alarm fires as the time registers roll into hh:mm:00, so look one second ahead.
    logic [5:0] w_nxt_min;
    logic [4:0] w_nxt_hour;
    logic       w_trigger;
    assign w_nxt_min  = (w_min == 6'(MINS - 1)) ? 6'd0 : w_min + 6'd1;
    assign w_nxt_hour = (w_min != 6'(MINS - 1))  ? w_hour :
                        (w_hour == 5'(HOURS - 1)) ? 5'd0 : w_hour + 5'd1;
    assign w_trigger  = w_tick_time & r_alarm_en & (w_sec == 6'(SECS - 1))
                      & (w_nxt_min == w_alm_min) & (w_nxt_hour == w_alm_hour);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_field_sel <= F_NONE;
        end else if (w_mode) begin
            case (r_state)
                ST_RUN:      begin r_state <= ST_SET_TIME;  r_field_sel <= F_HOUR; end
                ST_SET_TIME: begin r_state <= ST_SET_ALARM; r_field_sel <= F_HOUR; end
                default:     begin r_state <= ST_RUN;       r_field_sel <= F_NONE; end
            endcase
        end else if (w_turn) begin
            if (w_in_set_time) begin
                r_field_sel <= {r_field_sel[1:0], r_field_sel[2]};
            end else if (w_in_set_alarm) begin
                r_field_sel <= (r_field_sel == F_HOUR) ? F_MIN : F_HOUR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm_en <= 1'b0;
            r_blink    <= 1'b0;
        end else begin
            if (w_change & w_in_run) r_alarm_en <= ~r_alarm_en;
            if (tick_1hz)            r_blink    <= ~r_blink;
        end
    end

    // A fresh trigger always reloads the ring, even while already ringing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm_ring <= 1'b0;
            r_ring_cnt   <= '0;
        end else if (w_trigger) begin
            r_alarm_ring <= 1'b1;
            r_ring_cnt   <= RW'(RING_SECS);
        end else if (w_cancel) begin
            r_alarm_ring <= 1'b0;
            r_ring_cnt   <= '0;
        end else if (r_alarm_ring & tick_1hz) begin
            r_ring_cnt <= r_ring_cnt - RW'(1);
            if (r_ring_cnt == RW'(1)) r_alarm_ring <= 1'b0;
        end
    end

    assign hour       = w_hour;
    assign min        = w_min;
    assign sec        = w_sec;
    assign alm_hour   = w_alm_hour;
    assign alm_min    = w_alm_min;
    assign alarm_en   = r_alarm_en;
    assign state      = r_state;
    assign field_sel  = r_field_sel;
    assign blink      = r_blink;
    assign alarm_ring = r_alarm_ring;

endmodule
